// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory waits,
// EX redirects, load-use hazards and fetch stalls into register enables and
// flushes, and counts hazard events with wrap-around counters.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | normal issue; load-use and fetch stalls handled here
//  ST_REDIR | post-redirect bubbles while the new fetch stream arrives
module pipeline_hazard_ctrl #(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {ST_RUN, ST_REDIR} state_t;

    localparam logic [3:0] BUB_INIT = REDIRECT_BUBBLES[3:0];

    state_t           state_q, state_d;
    logic [3:0]       bub_q, bub_d;
    logic [CNT_W-1:0] load_use_cnt_q, mem_wait_cnt_q, flush_cnt_q;

    logic mem_stall, load_use, fetch_stall;
    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c, ex_mem_en_c;
    logic inc_lu, inc_mw, inc_fl;

    assign mem_stall   = dmem_req & ~dmem_ready;
    // x0 is hardwired, so a load targeting it never produces a hazard
    assign load_use    = ex_mem_read & id_valid & (ex_rd != 5'd0) &
                         ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                          (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign fetch_stall = ~imem_ready;

    // Prioritised hazard resolution: pipeline controls, next state, counter bumps
    always_comb begin
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_en_c    = 1'b0;
        id_ex_flush_c = 1'b0;
        ex_mem_en_c   = 1'b0;
        state_d       = state_q;
        bub_d         = bub_q;
        inc_lu        = 1'b0;
        inc_mw        = 1'b0;
        inc_fl        = 1'b0;
        if (mem_stall) begin
            // full freeze; a pending redirect is re-presented once EX thaws
            inc_mw = 1'b1;
        end else if (ex_redirect) begin
            pc_en_c       = 1'b1;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            ex_mem_en_c   = 1'b1;
            inc_fl        = 1'b1;
            if (REDIRECT_BUBBLES != 0) begin
                state_d = ST_REDIR;
                bub_d   = BUB_INIT;
            end else begin
                state_d = ST_RUN;
                bub_d   = 4'd0;
            end
        end else if (state_q == ST_REDIR) begin
            pc_en_c       = imem_ready;
            if_id_flush_c = 1'b1;
            id_ex_en_c    = 1'b1;
            ex_mem_en_c   = 1'b1;
            // only bubbles that saw valid fetch data count toward the window
            if (imem_ready) begin
                if (bub_q <= 4'd1) begin
                    bub_d   = 4'd0;
                    state_d = ST_RUN;
                end else begin
                    bub_d = bub_q - 4'd1;
                end
            end
        end else if (load_use) begin
            id_ex_flush_c = 1'b1;
            ex_mem_en_c   = 1'b1;
            inc_lu        = 1'b1;
        end else if (fetch_stall) begin
            if_id_flush_c = 1'b1;
            id_ex_en_c    = 1'b1;
            ex_mem_en_c   = 1'b1;
        end else begin
            pc_en_c    = 1'b1;
            if_id_en_c = 1'b1;
            id_ex_en_c = 1'b1;
            ex_mem_en_c = 1'b1;
        end
    end

    // Reset gates every control low immediately, without waiting for a clock
    assign pc_en       = pc_en_c       & rst_n;
    assign if_id_en    = if_id_en_c    & rst_n;
    assign if_id_flush = if_id_flush_c & rst_n;
    assign id_ex_en    = id_ex_en_c    & rst_n;
    assign id_ex_flush = id_ex_flush_c & rst_n;
    assign ex_mem_en   = ex_mem_en_c   & rst_n;

    assign load_use_cnt = load_use_cnt_q;
    assign mem_wait_cnt = mem_wait_cnt_q;
    assign flush_cnt    = flush_cnt_q;

    // FSM state, bubble counter and wrap-around performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            bub_q          <= 4'd0;
            load_use_cnt_q <= '0;
            mem_wait_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            if (inc_lu) load_use_cnt_q <= load_use_cnt_q + CNT_W'(1);
            if (inc_mw) mem_wait_cnt_q <= mem_wait_cnt_q + CNT_W'(1);
            if (inc_fl) flush_cnt_q    <= flush_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share stimulus:
// A uses 2 redirect bubbles and 4-bit counters, B uses 1 bubble and 32-bit.
// Control vectors are packed {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] C_NORMAL = 6'b110101;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_REDIR0 = 6'b101011;
    localparam logic [5:0] C_REDIRV = 6'b101101;
    localparam logic [5:0] C_REDIRW = 6'b001101;
    localparam logic [5:0] C_LDUSE  = 6'b000011;
    localparam logic [5:0] C_FETCH  = 6'b001101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic       dmem_req, dmem_ready, imem_ready;
    logic [4:0] id_rs1, id_rs2, ex_rd;

    logic        a_pc, a_ife, a_iff, a_ide, a_idf, a_exm;
    logic [3:0]  a_lu, a_mw, a_fl;
    logic        b_pc, b_ife, b_iff, b_ide, b_idf, b_exm;
    logic [31:0] b_lu, b_mw, b_fl;
    logic [5:0]  a_ctl, b_ctl;

    int total = 0;
    int bad   = 0;

    assign a_ctl = {a_pc, a_ife, a_iff, a_ide, a_idf, a_exm};
    assign b_ctl = {b_pc, b_ife, b_iff, b_ide, b_idf, b_exm};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(2), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .imem_ready(imem_ready), .pc_en(a_pc), .if_id_en(a_ife), .if_id_flush(a_iff),
        .id_ex_en(a_ide), .id_ex_flush(a_idf), .ex_mem_en(a_exm),
        .load_use_cnt(a_lu), .mem_wait_cnt(a_mw), .flush_cnt(a_fl)
    );

    pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(1), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .imem_ready(imem_ready), .pc_en(b_pc), .if_id_en(b_ife), .if_id_flush(b_iff),
        .id_ex_en(b_ide), .id_ex_flush(b_idf), .ex_mem_en(b_exm),
        .load_use_cnt(b_lu), .mem_wait_cnt(b_mw), .flush_cnt(b_fl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        ex_redirect = 1'b0;
        dmem_req    = 1'b0;
        dmem_ready  = 1'b1;
        imem_ready  = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        id_valid    = 1'b1;
        ex_mem_read = 1'b1;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_uses_rs1 = u1;
        id_rs2      = rs2;
        id_uses_rs2 = u2;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        chk("rst_ctl_a", 32'(a_ctl), 32'(C_FREEZE));
        chk("rst_ctl_b", 32'(b_ctl), 32'(C_FREEZE));
        chk("rst_cnt_a", 32'({a_lu, a_mw, a_fl}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_normal", 32'(a_ctl), 32'(C_NORMAL));
        tick();

        // load-use on rs2
        set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        #1 chk("lu_rs2_ctl", 32'(a_ctl), 32'(C_LDUSE));
        tick();
        idle();
        #1 chk("lu_clear_ctl", 32'(a_ctl), 32'(C_NORMAL));
        chk("lu_cnt1", 32'(a_lu), 32'd1);
        // x0 destination: no hazard
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 chk("lu_x0_ctl", 32'(a_ctl), 32'(C_NORMAL));
        tick();
        chk("lu_x0_cnt", 32'(a_lu), 32'd1);
        // rs1 match
        set_lu(5'd7, 5'd7, 1'b1, 5'd3, 1'b1);
        #1 chk("lu_rs1_ctl", 32'(a_ctl), 32'(C_LDUSE));
        tick();
        chk("lu_cnt2", 32'(a_lu), 32'd2);
        // register matches but is not read
        set_lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        #1 chk("lu_unused_ctl", 32'(a_ctl), 32'(C_NORMAL));
        // ID bubble
        set_lu(5'd7, 5'd7, 1'b1, 5'd7, 1'b1);
        id_valid = 1'b0;
        #1 chk("lu_invalid_ctl", 32'(a_ctl), 32'(C_NORMAL));
        idle();

        // fetch stall in RUN
        imem_ready = 1'b0;
        #1 chk("fetch_ctl", 32'(a_ctl), 32'(C_FETCH));
        tick();
        idle();

        // redirect with concurrent load-use
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        ex_redirect = 1'b1;
        #1 chk("redir_c0_ctl", 32'(a_ctl), 32'(C_REDIR0));
        tick();
        idle();
        #1 chk("redir_c1_ctl", 32'(a_ctl), 32'(C_REDIRV));
        chk("redir_c1_ctl_b", 32'(b_ctl), 32'(C_REDIRV));
        chk("redir_flush_cnt", 32'(a_fl), 32'd1);
        chk("redir_lu_cnt", 32'(a_lu), 32'd2);
        tick();
        #1 chk("redir_c2_ctl", 32'(a_ctl), 32'(C_REDIRV));
        chk("redir_c2_ctl_b", 32'(b_ctl), 32'(C_NORMAL));
        tick();
        #1 chk("redir_c3_ctl", 32'(a_ctl), 32'(C_NORMAL));

        // memory wait with pending redirect
        dmem_req    = 1'b1;
        dmem_ready  = 1'b0;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mw_freeze_ctl", 32'(a_ctl), 32'(C_FREEZE));
            tick();
        end
        chk("mw_cnt", 32'(a_mw), 32'd3);
        chk("mw_flush_hold", 32'(a_fl), 32'd1);
        dmem_ready = 1'b1;
        #1 chk("mw_redir_ctl", 32'(a_ctl), 32'(C_REDIR0));
        tick();
        idle();
        chk("mw_flush_cnt", 32'(a_fl), 32'd2);
        tick();
        tick();
        #1 chk("mw_back_normal", 32'(a_ctl), 32'(C_NORMAL));

        // REDIR with fetch data late
        ex_redirect = 1'b1;
        tick();
        idle();
        imem_ready = 1'b0;
        #1 chk("rw_c1_ctl_b", 32'(b_ctl), 32'(C_REDIRW));
        tick();
        #1 chk("rw_c2_ctl_b", 32'(b_ctl), 32'(C_REDIRW));
        tick();
        imem_ready = 1'b1;
        #1 chk("rw_c3_ctl_b", 32'(b_ctl), 32'(C_REDIRV));
        chk("rw_c3_ctl_a", 32'(a_ctl), 32'(C_REDIRV));
        tick();
        #1 chk("rw_c4_ctl_b", 32'(b_ctl), 32'(C_NORMAL));
        chk("rw_c4_ctl_a", 32'(a_ctl), 32'(C_REDIRV));
        tick();
        #1 chk("rw_c5_ctl_a", 32'(a_ctl), 32'(C_NORMAL));

        // counter wrap: 15 more load-use cycles, 17 in total
        set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        idle();
        #1 chk("wrap_cnt_a", 32'(a_lu), 32'd1);
        chk("wrap_cnt_b", b_lu, 32'd17);

        // reset mid-REDIR
        ex_redirect = 1'b1;
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_ctl", 32'(a_ctl), 32'(C_FREEZE));
        chk("mid_rst_cnt", 32'({a_lu, a_mw, a_fl}), 32'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("mid_rst_run", 32'(a_ctl), 32'(C_NORMAL));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
